// File: rtl/bidir_pin_tester_if.sv
// ----------------------------------------------------------------------------
// bidir_pin_tester_if
// Groups the control handshake, pad drive/readback and result masks of the
// bidirectional pad self-test sequencer.
//   start      : request a test run (tester input)
//   busy, done : sequence in progress / one-cycle completion pulse
//   pin_o      : value driven to each pad buffer input
//   pin_t      : per-pad tristate enable, 1 = released, 0 = driving
//   pin_i      : per-pad readback from the pad buffer output
//   channel    : pad currently under test
//   phase      : 0 = drive low, 1 = drive high, 2 = release
//   fail_mask  : sticky, pad did not read its own expected level
//   short_mask : sticky, released pad disturbed while another pad was driven
// slave is the sequencer side, master is the board/bench side.
// ----------------------------------------------------------------------------
interface bidir_pin_tester_if #(
    parameter int CHANNELS = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                start;
    logic                busy;
    logic                done;
    logic [CHANNELS-1:0] pin_o;
    logic [CHANNELS-1:0] pin_t;
    logic [CHANNELS-1:0] pin_i;
    logic [CH_W-1:0]     channel;
    logic [1:0]          phase;
    logic [CHANNELS-1:0] fail_mask;
    logic [CHANNELS-1:0] short_mask;

    modport slave (
        input  start, pin_i,
        output busy, done, pin_o, pin_t, channel, phase, fail_mask, short_mask
    );

    modport master (
        output start, pin_i,
        input  busy, done, pin_o, pin_t, channel, phase, fail_mask, short_mask
    );
endinterface

// File: rtl/bidir_pin_tester.sv
// ----------------------------------------------------------------------------
// bidir_pin_tester
// Self-test sequencer for CHANNELS bidirectional pads. On start it walks each
// pad through drive-low, drive-high and release, holds every pattern for
// SETTLE_CLOCKS cycles, samples the readback once, and records stuck pads
// (fail_mask) and pads disturbed by a neighbour (short_mask).
// Ports:
//   clock   : system clock, all logic on posedge
//   reset_n : synchronous active-low reset
//   bus     : bidir_pin_tester_if.slave (handshake, pad drive/readback, masks)
// Parameters:
//   CHANNELS      : number of pads under test (>= 1)
//   SETTLE_CLOCKS : cycles a pattern is held before sampling (>= 1)
//   EXPECT_PULL   : level a released pad reads (board pull-up 1 / pull-down 0)
//   CHECK_RELEASE : 1 checks the released level of the pad under test
// ----------------------------------------------------------------------------
module bidir_pin_tester #(
    parameter int CHANNELS      = 8,
    parameter int SETTLE_CLOCKS = 16,
    parameter bit EXPECT_PULL   = 1'b1,
    parameter bit CHECK_RELEASE = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    bidir_pin_tester_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CLOCKS + 1);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PH_LOW     = 2'd0,
        PH_HIGH    = 2'd1,
        PH_RELEASE = 2'd2
    } phase_e;

    state_e              state_q,   state_d;
    phase_e              phase_q,   phase_d;
    logic [CH_W-1:0]     channel_q, channel_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CHANNELS-1:0] pin_o_q,   pin_o_d;
    logic [CHANNELS-1:0] pin_t_q,   pin_t_d;
    logic [CHANNELS-1:0] fail_q,    fail_d;
    logic [CHANNELS-1:0] short_q,   short_d;
    logic                exp_own;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_LOW;
            channel_q <= '0;
            cnt_q     <= '0;
            pin_o_q   <= '0;
            pin_t_q   <= '1;
            fail_q    <= '0;
            short_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            channel_q <= channel_d;
            cnt_q     <= cnt_d;
            pin_o_q   <= pin_o_d;
            pin_t_q   <= pin_t_d;
            fail_q    <= fail_d;
            short_q   <= short_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, sampling and drive pattern
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        channel_d = channel_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        short_d   = short_q;
        exp_own   = EXPECT_PULL;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    fail_d    = '0;
                    short_d   = '0;
                    channel_d = '0;
                    phase_d   = PH_LOW;
                    cnt_d     = '0;
                    state_d   = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                // pin_i is asynchronous to the pattern, but it has been held
                // static for SETTLE_CLOCKS cycles, so one capture here is safe.
                unique case (phase_q)
                    PH_LOW:  exp_own = 1'b0;
                    PH_HIGH: exp_own = 1'b1;
                    default: exp_own = EXPECT_PULL;
                endcase

                if ((phase_q != PH_RELEASE) || CHECK_RELEASE) begin
                    if (bus.pin_i[channel_q] != exp_own) begin
                        fail_d[channel_q] = 1'b1;
                    end
                end

                // Only one pad drives in phases 0/1; any other pad off its
                // pull level is being pulled by the driven one.
                if (phase_q != PH_RELEASE) begin
                    for (int j = 0; j < CHANNELS; j++) begin
                        if ((j != int'(channel_q)) && (bus.pin_i[j] != EXPECT_PULL)) begin
                            short_d[j] = 1'b1;
                        end
                    end
                end

                cnt_d = '0;
                unique case (phase_q)
                    PH_LOW: begin
                        phase_d = PH_HIGH;
                        state_d = ST_SETTLE;
                    end
                    PH_HIGH: begin
                        phase_d = PH_RELEASE;
                        state_d = ST_SETTLE;
                    end
                    default: begin
                        if (channel_q == CH_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d   = PH_LOW;
                            channel_d = channel_q + 1'b1;
                            state_d   = ST_SETTLE;
                        end
                    end
                endcase
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pattern is registered from the next state so it is already valid
        // on the first SETTLE cycle; at most one pad is ever driven.
        pin_t_d = '1;
        pin_o_d = '0;
        if (((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) && (phase_d != PH_RELEASE)) begin
            pin_t_d[channel_d] = 1'b0;
            pin_o_d[channel_d] = (phase_d == PH_HIGH);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pin_o      = pin_o_q;
    assign bus.pin_t      = pin_t_q;
    assign bus.channel    = channel_q;
    assign bus.phase      = phase_q;
    assign bus.fail_mask  = fail_q;
    assign bus.short_mask = short_q;

endmodule

// File: tb/tb_bidir_pin_tester.sv
// ----------------------------------------------------------------------------
// tb_bidir_pin_tester
// Directed bench for bidir_pin_tester with CHANNELS=4, SETTLE_CLOCKS=4.
// Three instances cover the parameter sets: A (pull-up, release checked),
// B (pull-down, release not checked), C (pull-down, release checked). A pad
// model (pad = pin_t ? pull : pin_o, plus an injectable fault) feeds pin_i.
// Faults: 0 none, 1 pad 2 stuck low, 2 pads 1/2 shorted (wired-AND),
//         3 pad 3 floats high during the release phase only.
// ----------------------------------------------------------------------------
module tb_bidir_pin_tester;
    localparam int CH       = 4;
    localparam int SETTLE   = 4;
    localparam int BUSY_LEN = 3 * CH * (SETTLE + 1);  // 60

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start_r = 1'b0;
    int   sel     = 0;
    int   fault   = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bidir_pin_tester_if #(.CHANNELS(CH)) if_a ();
    bidir_pin_tester_if #(.CHANNELS(CH)) if_b ();
    bidir_pin_tester_if #(.CHANNELS(CH)) if_c ();

    bidir_pin_tester #(.CHANNELS(CH), .SETTLE_CLOCKS(SETTLE), .EXPECT_PULL(1'b1), .CHECK_RELEASE(1'b1))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a.slave));
    bidir_pin_tester #(.CHANNELS(CH), .SETTLE_CLOCKS(SETTLE), .EXPECT_PULL(1'b0), .CHECK_RELEASE(1'b0))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b.slave));
    bidir_pin_tester #(.CHANNELS(CH), .SETTLE_CLOCKS(SETTLE), .EXPECT_PULL(1'b0), .CHECK_RELEASE(1'b1))
        dut_c (.clock(clock), .reset_n(reset_n), .bus(if_c.slave));

    // Board model: released pads read the pull level, driven pads their pin_o.
    function automatic logic [CH-1:0] pad_model(input logic [CH-1:0] t, input logic [CH-1:0] o,
                                                input logic pull, input logic [1:0] ph, input int f);
        logic [CH-1:0] p;
        logic          v;
        for (int i = 0; i < CH; i++) p[i] = t[i] ? pull : o[i];
        case (f)
            1: p[2] = 1'b0;
            2: begin
                if (!t[1] || !t[2]) begin
                    v    = (t[1] ? pull : o[1]) & (t[2] ? pull : o[2]);
                    p[1] = v;
                    p[2] = v;
                end
            end
            3: if (t[3] && (ph == 2'd2)) p[3] = 1'b1;
            default: ;
        endcase
        return p;
    endfunction

    assign if_a.start = start_r && (sel == 0);
    assign if_b.start = start_r && (sel == 1);
    assign if_c.start = start_r && (sel == 2);
    assign if_a.pin_i = pad_model(if_a.pin_t, if_a.pin_o, 1'b1, if_a.phase, fault);
    assign if_b.pin_i = pad_model(if_b.pin_t, if_b.pin_o, 1'b0, if_b.phase, fault);
    assign if_c.pin_i = pad_model(if_c.pin_t, if_c.pin_o, 1'b0, if_c.phase, fault);

    logic          obs_busy, obs_done;
    logic [CH-1:0] obs_pin_t, obs_pin_o, obs_fail, obs_short;
    logic [1:0]    obs_channel, obs_phase;

    always_comb begin
        obs_busy = if_a.busy;   obs_done  = if_a.done;
        obs_pin_t = if_a.pin_t; obs_pin_o = if_a.pin_o;
        obs_fail = if_a.fail_mask; obs_short = if_a.short_mask;
        obs_channel = if_a.channel; obs_phase = if_a.phase;
        if (sel == 1) begin
            obs_busy = if_b.busy;   obs_done  = if_b.done;
            obs_pin_t = if_b.pin_t; obs_pin_o = if_b.pin_o;
            obs_fail = if_b.fail_mask; obs_short = if_b.short_mask;
            obs_channel = if_b.channel; obs_phase = if_b.phase;
        end else if (sel == 2) begin
            obs_busy = if_c.busy;   obs_done  = if_c.done;
            obs_pin_t = if_c.pin_t; obs_pin_o = if_c.pin_o;
            obs_fail = if_c.fail_mask; obs_short = if_c.short_mask;
            obs_channel = if_c.channel; obs_phase = if_c.phase;
        end
    end

    // Pulses start across one posedge, then measures the busy window.
    // repulse_at: busy cycle on which start is raised again (0 = never);
    // repulse_done: raise start during the done cycle too.
    task automatic run_sequence(input int repulse_at, input bit repulse_done,
                                output int busy_cycles, output logic done_end,
                                output logic done_after, output logic busy_after,
                                output bit pattern_bad);
        @(negedge clock); start_r = 1'b1;
        @(negedge clock); start_r = 1'b0;
        busy_cycles = 0;
        pattern_bad = 1'b0;
        while (obs_busy && (busy_cycles < 200)) begin
            busy_cycles++;
            if ($countones(~obs_pin_t) > 1) pattern_bad = 1'b1;
            if ((obs_pin_o & obs_pin_t) != '0) pattern_bad = 1'b1;
            start_r = (busy_cycles == repulse_at);
            @(negedge clock);
        end
        done_end = obs_done;
        if (obs_pin_t != '1) pattern_bad = 1'b1;
        start_r = repulse_done;
        @(negedge clock);
        start_r    = 1'b0;
        done_after = obs_done;
        @(negedge clock);
        busy_after = obs_busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if ({obs_busy, obs_done} !== 2'b00) begin n_bad++;
            $display("FAIL reset_busy_done: observed %b expected 00", {obs_busy, obs_done}); end
        n_cmp++; if (obs_pin_t !== 4'b1111) begin n_bad++;
            $display("FAIL reset_pin_t: observed %b expected 1111", obs_pin_t); end
        n_cmp++; if (obs_pin_o !== 4'b0000) begin n_bad++;
            $display("FAIL reset_pin_o: observed %b expected 0000", obs_pin_o); end
        n_cmp++; if ({obs_channel, obs_phase} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_channel_phase: observed %b expected 0000", {obs_channel, obs_phase}); end
        n_cmp++; if ({obs_fail, obs_short} !== 8'h00) begin n_bad++;
            $display("FAIL reset_masks: observed %h expected 00", {obs_fail, obs_short}); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Shared scoring of one full sequence against its expected masks.
    task automatic test_sequence(input string name, input int which, input int flt,
                                 input logic [CH-1:0] exp_fail, input logic [CH-1:0] exp_short);
        int busy_cycles; logic done_end, done_after, busy_after; bit pattern_bad;
        sel = which; fault = flt;
        run_sequence(0, 1'b0, busy_cycles, done_end, done_after, busy_after, pattern_bad);
        n_cmp++; if (busy_cycles != BUSY_LEN) begin n_bad++;
            $display("FAIL %s busy_len: observed %0d expected %0d", name, busy_cycles, BUSY_LEN); end
        n_cmp++; if ({done_end, done_after} !== 2'b10) begin n_bad++;
            $display("FAIL %s done_pulse: observed %b expected 10", name, {done_end, done_after}); end
        n_cmp++; if (obs_fail !== exp_fail) begin n_bad++;
            $display("FAIL %s fail_mask: observed %b expected %b", name, obs_fail, exp_fail); end
        n_cmp++; if (obs_short !== exp_short) begin n_bad++;
            $display("FAIL %s short_mask: observed %b expected %b", name, obs_short, exp_short); end
        n_cmp++; if (pattern_bad) begin n_bad++;
            $display("FAIL %s drive_pattern: observed illegal expected one pad max", name); end
    endtask

    task automatic test_start_ignored();
        int busy_cycles; logic done_end, done_after, busy_after; bit pattern_bad;
        sel = 0; fault = 0;
        run_sequence(10, 1'b1, busy_cycles, done_end, done_after, busy_after, pattern_bad);
        n_cmp++; if (busy_cycles != BUSY_LEN) begin n_bad++;
            $display("FAIL ignore busy_len: observed %0d expected %0d", busy_cycles, BUSY_LEN); end
        n_cmp++; if ({done_end, done_after, busy_after} !== 3'b100) begin n_bad++;
            $display("FAIL ignore no_restart: observed %b expected 100", {done_end, done_after, busy_after}); end
        n_cmp++; if ({obs_fail, obs_short} !== 8'h00) begin n_bad++;
            $display("FAIL ignore masks: observed %h expected 00", {obs_fail, obs_short}); end
    endtask

    task automatic test_reset_midrun();
        int n;
        sel = 0; fault = 1;
        @(negedge clock); start_r = 1'b1;
        @(negedge clock); start_r = 1'b0;
        n = 1;
        while (n < 25) begin @(negedge clock); n++; end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_cmp++; if (obs_busy !== 1'b0) begin n_bad++;
            $display("FAIL midreset busy: observed %b expected 0", obs_busy); end
        n_cmp++; if (obs_pin_t !== 4'b1111) begin n_bad++;
            $display("FAIL midreset pin_t: observed %b expected 1111", obs_pin_t); end
        n_cmp++; if ({obs_fail, obs_short} !== 8'h00) begin n_bad++;
            $display("FAIL midreset masks: observed %h expected 00", {obs_fail, obs_short}); end
        @(negedge clock);
        test_sequence("after_reset", 0, 0, 4'b0000, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_sequence("healthy",    0, 0, 4'b0000, 4'b0000);
        test_sequence("stuck_low",  0, 1, 4'b0100, 4'b0100);
        test_sequence("short_1_2",  0, 2, 4'b0000, 4'b0110);
        test_start_ignored();
        test_reset_midrun();
        test_sequence("float_norel", 1, 3, 4'b0000, 4'b0000);
        test_sequence("float_rel",   2, 3, 4'b1000, 4'b0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
